pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 pipe. It generates the stall and bubble signals for the F, D, E, M and W pipeline registers from hazard conditions: load/use, ret, branch mispredict and exception. It also sequences a post-reset flush, enters and holds a halted state when a non-AOK status retires, and keeps performance counters. It sits beside fetch/decode/execute/memory/writeback and drives their F_stall, D_stall, D_bubble, E_bubble, M_bubble and W_stall inputs.

---
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, post-reset flush sequencing,
// halt on a non-AOK retirement and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [0:3]       m_stat,
    input  logic [0:3]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [0:3]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [0:3] S_AOK    = 4'b1000;

    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StFlush, StRun, StHalted} state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [0:3]       cpu_stat_q, cpu_stat_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic loaduse, mispred, retq, exc_m, exc_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred = (E_icode == I_JXX) && !e_Cnd;
        retq    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        exc_m   = (m_stat != S_AOK);
        exc_w   = (W_stat != S_AOK);
    end

    // Reset overrides every state so the pipe registers are flushed while reset is held.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        if (reset || (state_q == StFlush)) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (state_q == StRun) begin
            F_stall  = loaduse || retq;
            D_stall  = loaduse;
            D_bubble = mispred || (retq && !loaduse);
            E_bubble = mispred || loaduse;
            M_bubble = exc_m || exc_w;
            W_stall  = exc_w;
        end else begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        cpu_stat_d   = cpu_stat_q;
        cycle_cnt_d  = cycle_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        unique case (state_q)
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = StRun;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            StRun: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (!exc_w && (W_icode != I_NOP)) begin
                    instr_cnt_d = sat_inc(instr_cnt_q);
                end
                if (D_bubble || E_bubble) begin
                    bubble_cnt_d = sat_inc(bubble_cnt_q);
                end
                if (exc_w) begin
                    state_d    = StHalted;
                    cpu_stat_d = W_stat;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StFlush;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFlush;
            flush_cnt_q  <= '0;
            cpu_stat_q   <= S_AOK;
            cycle_cnt_q  <= '0;
            instr_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            cpu_stat_q   <= cpu_stat_d;
            cycle_cnt_q  <= cycle_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign halted     = (state_q == StHalted);
    assign cpu_stat   = cpu_stat_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign instr_cnt  = instr_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model pushes expected outputs per cycle,
// which are popped and compared mid-cycle; a second instance checks 4-bit saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_Cnd;
    logic [0:3] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [0:3]  cpu_stat;
    logic [31:0] cycle_cnt, instr_cnt, bubble_cnt;

    logic       f4, ds4, db4, eb4, mb4, ws4, h4;
    logic [0:3] cs4;
    logic [3:0] cyc4, ins4, bub4;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted), .cpu_stat(cpu_stat),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(f4), .D_stall(ds4), .D_bubble(db4), .E_bubble(eb4),
        .M_bubble(mb4), .W_stall(ws4), .halted(h4), .cpu_stat(cs4),
        .cycle_cnt(cyc4), .instr_cnt(ins4), .bubble_cnt(bub4)
    );

    typedef struct packed {
        logic [6:0]  ctl;
        logic [3:0]  stat;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] bub;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = flush, 1 = run, 2 = halted
    int          m_st;
    int          m_fcnt;
    logic [3:0]  m_cpu;
    logic [31:0] m_cyc, m_ins, m_bub;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}
    function automatic logic [6:0] model_ctl();
        logic lu, mp, rt, em, ew;
        logic h;
        h  = (m_st == 2);
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        mp = (E_icode == 4'h7) && !e_Cnd;
        rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        em = (m_stat != 4'b1000);
        ew = (W_stat != 4'b1000);
        if (reset || m_st == 0) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, h};
        if (m_st == 1) return {lu | rt, lu, mp | (rt & ~lu), mp | lu, em | ew, ew, 1'b0};
        return 7'b1100111;
    endfunction

    task automatic model_update(input logic [6:0] ctl);
        if (reset) begin
            m_st = 0; m_fcnt = 0; m_cpu = 4'b1000;
            m_cyc = 0; m_ins = 0; m_bub = 0;
        end else if (m_st == 0) begin
            if (m_fcnt == 3) m_st = 1;
            else m_fcnt++;
        end else if (m_st == 1) begin
            m_cyc++;
            if (W_stat == 4'b1000 && W_icode != 4'h1) m_ins++;
            if (ctl[4] || ctl[3]) m_bub++;
            if (W_stat != 4'b1000) begin
                m_st  = 2;
                m_cpu = W_stat;
            end
        end
    endtask

    task automatic step();
        exp_t e, g;
        e.ctl  = model_ctl();
        e.stat = m_cpu;
        e.cyc  = m_cyc;
        e.ins  = m_ins;
        e.bub  = m_bub;
        sb.push_back(e);
        #4;
        g = sb.pop_front();
        check_eq("ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}, g.ctl);
        check_eq("cpu_stat", cpu_stat, g.stat);
        check_eq("cycle_cnt", cycle_cnt, g.cyc);
        check_eq("instr_cnt", instr_cnt, g.ins);
        check_eq("bubble_cnt", bubble_cnt, g.bub);
        check_eq("stall_bubble_excl", D_stall & D_bubble, 0);
        check_eq("cycle_cnt4", cyc4, sat4(g.cyc));
        check_eq("instr_cnt4", ins4, sat4(g.ins));
        model_update(g.ctl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
        m_stat = 4'b1000; W_stat = 4'b1000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    logic [3:0] ics [6];

    initial begin
        ics = '{4'h1, 4'h5, 4'h7, 4'h9, 4'h6, 4'hB};
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_st = 0; m_fcnt = 0; m_cpu = 4'b1000; m_cyc = 0; m_ins = 0; m_bub = 0;
        do_reset();
        step();
        check_eq("run_after_flush", F_stall, 0);

        // load/use, then the same load with no matching source
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        step();
        E_dstM = 4'hF; d_srcA = 4'hF;
        step();
        idle();

        // mispredicted branch
        E_icode = 4'h7; e_Cnd = 1'b0;
        step();
        idle();

        // ret walking down D/E/M, then ret combined with load/use
        M_icode = 4'h9; step(); idle();
        D_icode = 4'h9; step(); idle();
        E_icode = 4'h9; step(); idle();
        M_icode = 4'h9; step(); idle();
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        step();
        idle();

        // retiring instructions, then a memory-stage exception
        W_icode = 4'h6; repeat (3) step();
        m_stat = 4'b0010; step(); idle();

        // halt on HLT retirement, hold, then reset out of it
        W_stat = 4'b0100; W_icode = 4'h0;
        step();
        idle();
        check_eq("halted", halted, 1);
        check_eq("halt_cpu_stat", cpu_stat, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            E_icode = ics[$urandom_range(0, 5)];
            W_stat  = 4'b0010;
            W_icode = 4'h6;
            step();
        end
        idle();
        do_reset();
        check_eq("reset_cpu_stat", cpu_stat, 4'b1000);

        // saturation of the 4-bit instance
        W_icode = 4'h6;
        repeat (20) step();
        check_eq("sat_cycle4", cyc4, 4'd15);
        check_eq("sat_instr4", ins4, 4'd15);
        idle();

        // random hazards with valid retirements
        for (int i = 0; i < 300; i++) begin
            D_icode = ics[$urandom_range(0, 5)];
            E_icode = ics[$urandom_range(0, 5)];
            M_icode = ics[$urandom_range(0, 5)];
            W_icode = ics[$urandom_range(0, 5)];
            d_srcA  = 4'($urandom_range(0, 15));
            d_srcB  = 4'($urandom_range(0, 15));
            E_dstM  = 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 7) == 0) ? 4'b0001 : 4'b1000;
            step();
        end
        idle();
        W_stat = 4'b0001;
        step();
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
